// File: rtl/rd_sched_s_if.sv
// Read-buffer handshake bus between the read scheduler (master) and the buffer (slave).
// The address is held by the master for as long as the request is up.
interface rd_sched_s_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              rd_req_o;
  logic              rd_ack_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;

  modport master (
    output rd_req_o,
    output rd_addr_o,
    input  rd_ack_i,
    input  rd_data_i
  );

  modport slave (
    input  rd_req_o,
    input  rd_addr_o,
    output rd_ack_i,
    output rd_data_i
  );
endinterface

// File: rtl/rd_sched_s.sv
// Read scheduler: queues synchronized read pulses and issues them to the buffer one at a time,
// capturing the returned data into a strobed output register.
//
// state | meaning
// IDLE  | no request outstanding, waiting for pend_o != 0
// REQ   | rd_req_o high, rd_addr_o held, waiting for rd_ack_i
// CAP   | data just captured, data_vld_o high for this one cycle
module rd_sched_s #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk_s,
  input  logic              rstn_s,
  input  logic              rd_en_i,
  rd_sched_s_if.master      bus,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld_o,
  output logic [CNT_W-1:0]  pend_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

  state_t            state_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              vld_q;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              accept;

  // rd_req_q is high exactly in REQ, so an ack in any other state is ignored here
  assign accept = rd_req_q & bus.rd_ack_i;

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (rd_en_i && !accept) begin
      if (pend_q == '1) ovf_d = 1'b1;
      else              pend_d = pend_q + 1'b1;
    end else if (accept && !rd_en_i) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state_q  <= IDLE;
      rd_req_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      vld_q  <= accept;
      if (accept) begin
        data_q <= bus.rd_data_i;
        addr_q <= addr_q + 1'b1;
      end
      // CAP looks at the already-updated count, so a request arriving with the accept keeps the chain going
      case (state_q)
        IDLE: begin
          if (pend_q != '0) begin
            state_q  <= REQ;
            rd_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.rd_ack_i) begin
            state_q  <= CAP;
            rd_req_q <= 1'b0;
          end
        end
        CAP: begin
          if (pend_q != '0) begin
            state_q  <= REQ;
            rd_req_q <= 1'b1;
          end else begin
            state_q  <= IDLE;
            rd_req_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_req_o  = rd_req_q;
  assign bus.rd_addr_o = addr_q;
  assign data_o        = data_q;
  assign data_vld_o    = vld_q;
  assign pend_o        = pend_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_rd_sched_s.sv
// Bench for rd_sched_s: cycle model of the request/capture rules compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rd_sched_s;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk_s = 1'b0;
  logic              rstn_s = 1'b0;
  logic              rd_en_i;
  logic [DATA_W-1:0] data_o;
  logic              data_vld_o;
  logic [CNT_W-1:0]  pend_o;
  logic              ovf_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_s = ~clk_s;

  rd_sched_s_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rd_sched_s #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_s      (clk_s),
    .rstn_s     (rstn_s),
    .rd_en_i    (rd_en_i),
    .bus        (bus),
    .data_o     (data_o),
    .data_vld_o (data_vld_o),
    .pend_o     (pend_o),
    .ovf_o      (ovf_o)
  );

  // buffer content: word at address a is 0xA0 | a
  assign bus.rd_data_i = {4'hA, bus.rd_addr_o};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one request in flight at a time, count of queued work saturating at 15,
  // a request is raised the cycle after there is work and nothing was just accepted.
  logic       m_req, m_vld, m_ovf;
  int         m_pend, m_addr;
  logic [7:0] m_data;
  logic       m_acc;
  assign m_acc = m_req && bus.rd_ack_i;

  always @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      m_req  <= 1'b0;
      m_vld  <= 1'b0;
      m_ovf  <= 1'b0;
      m_pend <= 0;
      m_addr <= 0;
      m_data <= 8'h00;
    end else begin
      m_req <= !m_acc && (m_req || m_pend != 0);
      m_vld <= m_acc;
      if (m_acc) begin
        m_data <= bus.rd_data_i;
        m_addr <= (m_addr + 1) % 16;
      end
      if (rd_en_i && !m_acc) begin
        if (m_pend == 15) m_ovf <= 1'b1;
        else              m_pend <= m_pend + 1;
      end else if (m_acc && !rd_en_i) begin
        m_pend <= m_pend - 1;
      end
    end
  end

  int acc_q[$];
  int peak;

  always @(negedge clk_s) begin
    if (rstn_s) begin
      chk("cyc_req",  int'(bus.rd_req_o),  int'(m_req));
      chk("cyc_addr", int'(bus.rd_addr_o), m_addr);
      chk("cyc_data", int'(data_o),        int'(m_data));
      chk("cyc_vld",  int'(data_vld_o),    int'(m_vld));
      chk("cyc_pend", int'(pend_o),        m_pend);
      chk("cyc_ovf",  int'(ovf_o),         int'(m_ovf));
      if (bus.rd_req_o && bus.rd_ack_i) acc_q.push_back(int'(bus.rd_addr_o));
      if (int'(pend_o) > peak) peak = int'(pend_o);
    end
  end

  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  task automatic do_reset();
    rstn_s = 1'b0;
    #2;
    rstn_s = 1'b1;
    step();
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!bus.rd_req_o && n < max) begin
      step();
      n++;
    end
    chk("wait_req_timeout", int'(bus.rd_req_o), 1);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((pend_o != 0 || bus.rd_req_o || data_vld_o) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", int'(pend_o != 0 || bus.rd_req_o || data_vld_o), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  int'(bus.rd_req_o),  0);
    chk({tag, "_addr"}, int'(bus.rd_addr_o), 0);
    chk({tag, "_data"}, int'(data_o),        0);
    chk({tag, "_vld"},  int'(data_vld_o),    0);
    chk({tag, "_pend"}, int'(pend_o),        0);
    chk({tag, "_ovf"},  int'(ovf_o),         0);
  endtask

  initial begin
    rd_en_i = 1'b0;
    bus.rd_ack_i = 1'b0;
    peak = 0;
    #22;
    chk_reset_vals("rst");
    @(negedge clk_s);
    rstn_s = 1'b1;
    step();

    // single request, ack held high
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    bus.rd_ack_i = 1'b1;
    chk("single_pend1", int'(pend_o), 1);
    chk("single_noreq", int'(bus.rd_req_o), 0);
    step();
    chk("single_req", int'(bus.rd_req_o), 1);
    chk("single_addr0", int'(bus.rd_addr_o), 0);
    step();
    chk("single_vld", int'(data_vld_o), 1);
    chk("single_data", int'(data_o), 8'hA0);
    chk("single_addr1", int'(bus.rd_addr_o), 1);
    chk("single_pend0", int'(pend_o), 0);
    step();
    chk("single_vld_off", int'(data_vld_o), 0);
    chk("single_idle", int'(bus.rd_req_o), 0);
    bus.rd_ack_i = 1'b0;

    // burst of three with a stalled first ack
    do_reset();
    acc_q.delete();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      rd_en_i = 1'b1;
      step();
    end
    rd_en_i = 1'b0;
    wait_req(10);
    repeat (3) begin
      step();
      chk("stall_req", int'(bus.rd_req_o), 1);
      chk("stall_addr", int'(bus.rd_addr_o), 0);
    end
    bus.rd_ack_i = 1'b1;
    wait_drain(20);
    bus.rd_ack_i = 1'b0;
    chk("burst_peak", peak, 3);
    chk("burst_n", acc_q.size(), 3);
    for (int i = 0; i < acc_q.size() && i < 3; i++) chk("burst_addr", acc_q[i], i);
    chk("burst_pend_end", int'(pend_o), 0);

    // new request arriving in the same cycle as an accept
    do_reset();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    wait_req(5);
    rd_en_i = 1'b1;
    bus.rd_ack_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    bus.rd_ack_i = 1'b0;
    chk("simul_vld", int'(data_vld_o), 1);
    chk("simul_pend", int'(pend_o), 1);
    step();
    chk("simul_rereq", int'(bus.rd_req_o), 1);
    chk("simul_pend2", int'(pend_o), 1);
    bus.rd_ack_i = 1'b1;
    wait_drain(10);
    bus.rd_ack_i = 1'b0;

    // saturation: 17 pulses, nothing acked
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      rd_en_i = 1'b1;
      step();
      if (i == 15) begin
        chk("sat_pend15", int'(pend_o), 15);
        chk("sat_ovf_not_yet", int'(ovf_o), 0);
      end
      if (i == 16) chk("sat_ovf16", int'(ovf_o), 1);
    end
    rd_en_i = 1'b0;
    chk("sat_pend", int'(pend_o), 15);
    chk("sat_ovf", int'(ovf_o), 1);
    bus.rd_ack_i = 1'b1;
    wait_drain(60);
    bus.rd_ack_i = 1'b0;
    chk("sat_ovf_sticky", int'(ovf_o), 1);
    chk("sat_drained", int'(pend_o), 0);

    // asynchronous reset while requesting with five queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd_en_i = 1'b1;
      step();
    end
    rd_en_i = 1'b0;
    chk("mid_pend5", int'(pend_o), 5);
    chk("mid_req", int'(bus.rd_req_o), 1);
    bus.rd_ack_i = 1'b1;
    #2;
    rstn_s = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    #10;
    rstn_s = 1'b1;
    step();
    chk("mid_after_req", int'(bus.rd_req_o), 0);
    chk("mid_after_vld", int'(data_vld_o), 0);
    chk("mid_after_addr", int'(bus.rd_addr_o), 0);
    chk("mid_after_pend", int'(pend_o), 0);
    bus.rd_ack_i = 1'b0;

    // address wrap over 17 accepted reads
    do_reset();
    acc_q.delete();
    bus.rd_ack_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
      step();
    end
    wait_drain(40);
    bus.rd_ack_i = 1'b0;
    chk("wrap_n", acc_q.size(), 17);
    for (int i = 0; i < acc_q.size() && i < 17; i++) chk("wrap_addr", acc_q[i], i % 16);
    chk("wrap_final_addr", int'(bus.rd_addr_o), 1);
    chk("wrap_last_data", int'(data_o), 8'hA0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
